lsu_access_unit: RTL and testbench

- Load/store unit sitting directly upstream of the write-back stage in the npc core.
- Accepts one memory operation per handshake from execute (address from ALU result, store data from rs2, func3 width) and drives a single-outstanding request/response memory port.
- Forms byte-lane write data and the write mask; extracts and sign/zero-extends load data.
- Presents the final 32-bit load result to write-back through a valid/ready handshake.

---
 rtl/lsu_access_unit.sv | 175 +++++++++++++++++
 tb/tb_lsu_access_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_access_unit.sv
// rtl/lsu_access_unit.sv - load/store access unit; misaligned-access trap enabled by LSU_MISALIGN_CHECK_EN
module lsu_access_unit #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_wen,
  input  logic [2:0]       in_width,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_wdata,
  input  logic [TAG_W-1:0] in_tag,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [31:0]      mem_req_addr,
  output logic             mem_req_wen,
  output logic [31:0]      mem_req_wdata,
  output logic [3:0]       mem_req_wmask,
  input  logic             mem_resp_valid,
  input  logic [31:0]      mem_resp_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_rdata,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t           state;
  logic             wen_q;
  logic [2:0]       width_q;
  logic [1:0]       lane_q;
  logic [TAG_W-1:0] tag_q;

  logic [3:0]       st_mask;
  logic [31:0]      st_data;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_data;

  // Store lane formation: width[1:0] picks byte/half/word, illegal codes fall to word
  always_comb begin
    st_mask = 4'b1111;
    st_data = in_wdata;
    case (in_width[1:0])
      2'b00: begin
        st_mask = 4'b0001 << in_addr[1:0];
        st_data = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        st_mask = in_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{in_wdata[15:0]}};
      end
      default: begin
        st_mask = 4'b1111;
        st_data = in_wdata;
      end
    endcase
  end

  // Load extraction from the raw response word; width[2] selects zero-extension
  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = mem_resp_rdata[7:0];
      2'd1:    ld_byte = mem_resp_rdata[15:8];
      2'd2:    ld_byte = mem_resp_rdata[23:16];
      default: ld_byte = mem_resp_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? mem_resp_rdata[31:16] : mem_resp_rdata[15:0];
    case (width_q[1:0])
      2'b00:   ld_data = {{24{ld_byte[7] & ~width_q[2]}}, ld_byte};
      2'b01:   ld_data = {{16{ld_half[15] & ~width_q[2]}}, ld_half};
      default: ld_data = mem_resp_rdata;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  logic misalign;
  logic err_q;

  // Half needs addr[0]=0, word (including illegal codes) needs addr[1:0]=0
  always_comb begin
    case (in_width[1:0])
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = in_addr[0];
      default: misalign = |in_addr[1:0];
    endcase
  end

  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

  // Access sequencer: one outstanding operation, all outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      out_valid     <= 1'b0;
      out_rdata     <= '0;
      out_tag       <= '0;
      wen_q         <= 1'b0;
      width_q       <= '0;
      lane_q        <= '0;
      tag_q         <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      err_q         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready      <= 1'b0;
            wen_q         <= in_wen;
            width_q       <= in_width;
            lane_q        <= in_addr[1:0];
            tag_q         <= in_tag;
            mem_req_addr  <= {in_addr[31:2], 2'b00};
            mem_req_wen   <= in_wen;
            mem_req_wdata <= in_wen ? st_data : 32'h0;
            mem_req_wmask <= in_wen ? st_mask : 4'b0000;
`ifdef LSU_MISALIGN_CHECK_EN
            if (misalign) begin
              // Trapped access never reaches memory
              err_q     <= 1'b1;
              out_valid <= 1'b1;
              out_rdata <= '0;
              out_tag   <= in_tag;
              state     <= DONE;
            end else begin
              err_q         <= 1'b0;
              mem_req_valid <= 1'b1;
              state         <= REQ;
            end
`else
            mem_req_valid <= 1'b1;
            state         <= REQ;
`endif
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= RESP;
          end
        end
        RESP: begin
          if (mem_resp_valid) begin
            out_rdata <= wen_q ? 32'h0 : ld_data;
            out_tag   <= tag_q;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_access_unit.sv
// tb/tb_lsu_access_unit.sv - scoreboard bench for lsu_access_unit
module tb_lsu_access_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_wen;
  logic [2:0]  in_width;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [7:0]  in_tag;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [7:0]  out_tag;
  logic        out_err;

  lsu_access_unit #(.TAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_width(in_width),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_tag(in_tag),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_tag(out_tag), .out_err(out_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic [7:0]  tag;
    logic        err;
  } out_t;

  req_t exp_req[$];
  out_t exp_out[$];

  int          n_chk = 0;
  int          n_fail = 0;
  int          req_cnt = 0;
  int          n_exp_req = 0;
  logic [31:0] resp_data = 32'h0;
  logic        resp_en = 1'b1;
  logic        force_resp = 1'b0;
  logic        pend = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endfunction

  // Memory responder: one response the cycle after each accepted request
  initial begin
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if ((pend && resp_en) || force_resp) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = resp_data;
      end
      pend = mem_req_valid && mem_req_ready && rst_n;
    end
  end

  // Request monitor: fields checked every valid cycle, popped on handshake
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && mem_req_valid) begin
        if (exp_req.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_req: got addr %h expected no request", mem_req_addr);
        end else begin
          chk("req_addr", mem_req_addr, exp_req[0].addr);
          chk1("req_wen", mem_req_wen, exp_req[0].wen);
          chk("req_wmask", {28'h0, mem_req_wmask}, {28'h0, exp_req[0].mask});
          if (exp_req[0].wen) chk("req_wdata", mem_req_wdata, exp_req[0].wdata);
          chk1("in_ready_busy_req", in_ready, 1'b0);
          if (mem_req_ready) begin
            void'(exp_req.pop_front());
            req_cnt++;
          end
        end
      end
    end
  end

  // Output monitor: results checked every valid cycle, popped on handshake
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (exp_out.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out: got rdata %h expected no output", out_rdata);
        end else begin
          chk("out_rdata", out_rdata, exp_out[0].rdata);
          chk("out_tag", {24'h0, out_tag}, {24'h0, exp_out[0].tag});
          chk1("out_err", out_err, exp_out[0].err);
          chk1("in_ready_busy_out", in_ready, 1'b0);
          if (out_ready) void'(exp_out.pop_front());
        end
      end
    end
  end

  // One complete access; waited returns cycles after accept edge until out_valid seen
  task automatic run_op(
    input logic        wen,
    input logic [2:0]  w,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [7:0]  tg,
    input logic [31:0] resp,
    input logic        ereq,
    input logic [31:0] ewdata,
    input logic [3:0]  emask,
    input logic [31:0] erdata,
    input logic        eerr,
    input int          rstall,
    input int          ostall,
    output int         waited,
    output logic       req_at_e0
  );
    int n;
    if (ereq) begin
      exp_req.push_back('{{a[31:2], 2'b00}, wen, ewdata, emask});
      n_exp_req++;
    end
    exp_out.push_back('{erdata, tg, eerr});
    resp_data     = resp;
    mem_req_ready = (rstall == 0);
    out_ready     = (ostall == 0);
    in_valid = 1'b1;
    in_wen   = wen;
    in_width = w;
    in_addr  = a;
    in_wdata = wd;
    in_tag   = tg;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    req_at_e0 = mem_req_valid;
    if (rstall > 0) begin
      repeat (rstall) @(posedge clk);
      #1;
      mem_req_ready = 1'b1;
    end
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    waited = n;
    if (!out_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL out_timeout: got no out_valid expected one within 50 cycles");
    end else begin
      if (ostall > 0) begin
        repeat (ostall) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    chk1("in_ready_after", in_ready, 1'b1);
    chk1("out_valid_after", out_valid, 1'b0);
    chk("req_count", 32'(req_cnt), 32'(n_exp_req));
    mem_req_ready = 1'b1;
    out_ready     = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w;
    logic r0;
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    in_wen        = 1'b0;
    in_width      = 3'b000;
    in_addr       = 32'h0;
    in_wdata      = 32'h0;
    in_tag        = 8'h0;
    mem_req_ready = 1'b1;
    out_ready     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_req_valid", mem_req_valid, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_rdata", out_rdata, 32'h0);
    chk("rst_out_tag", {24'h0, out_tag}, 32'h0);
    chk1("rst_out_err", out_err, 1'b0);
    chk("rst_req_addr", mem_req_addr, 32'h0);
    chk("rst_req_wdata", mem_req_wdata, 32'h0);
    chk("rst_req_wmask", {28'h0, mem_req_wmask}, 32'h0);
    chk1("rst_req_wen", mem_req_wen, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // sb at lane 3, minimum latency
    run_op(1'b1, 3'b000, 32'h8000_0003, 32'h0000_00AB, 8'h11, 32'h0,
           1'b1, 32'hABAB_ABAB, 4'b1000, 32'h0, 1'b0, 0, 0, w, r0);
    chk1("sb_req_at_edge0", r0, 1'b1);
    chk("sb_out_latency", 32'(w), 32'd2);

    run_op(1'b0, 3'b000, 32'h8000_0002, 32'h0, 8'h22, 32'h12F4_5678,
           1'b1, 32'h0, 4'b0000, 32'hFFFF_FFF4, 1'b0, 0, 0, w, r0);
    run_op(1'b0, 3'b100, 32'h8000_0002, 32'h0, 8'h23, 32'h12F4_5678,
           1'b1, 32'h0, 4'b0000, 32'h0000_00F4, 1'b0, 0, 0, w, r0);
    run_op(1'b0, 3'b001, 32'h8000_0002, 32'h0, 8'h24, 32'h8001_5678,
           1'b1, 32'h0, 4'b0000, 32'hFFFF_8001, 1'b0, 0, 0, w, r0);
    run_op(1'b0, 3'b101, 32'h8000_0002, 32'h0, 8'h25, 32'h8001_5678,
           1'b1, 32'h0, 4'b0000, 32'h0000_8001, 1'b0, 0, 0, w, r0);
    run_op(1'b1, 3'b001, 32'h8000_0006, 32'h0000_BEEF, 8'h26, 32'h0,
           1'b1, 32'hBEEF_BEEF, 4'b1100, 32'h0, 1'b0, 0, 0, w, r0);
    run_op(1'b1, 3'b001, 32'h8000_0004, 32'h1234_5678, 8'h27, 32'h0,
           1'b1, 32'h5678_5678, 4'b0011, 32'h0, 1'b0, 0, 0, w, r0);
    run_op(1'b1, 3'b010, 32'h8000_0010, 32'h1234_5678, 8'h28, 32'h0,
           1'b1, 32'h1234_5678, 4'b1111, 32'h0, 1'b0, 0, 0, w, r0);
    run_op(1'b1, 3'b000, 32'h8000_0001, 32'h0000_0055, 8'h29, 32'h0,
           1'b1, 32'h5555_5555, 4'b0010, 32'h0, 1'b0, 0, 0, w, r0);
    run_op(1'b0, 3'b000, 32'h8000_0000, 32'h0, 8'h2A, 32'h0000_007F,
           1'b1, 32'h0, 4'b0000, 32'h0000_007F, 1'b0, 0, 0, w, r0);
    run_op(1'b0, 3'b011, 32'h8000_0008, 32'h0, 8'h2B, 32'hCAFE_F00D,
           1'b1, 32'h0, 4'b0000, 32'hCAFE_F00D, 1'b0, 0, 0, w, r0);

    // backpressure on both request and result
    run_op(1'b0, 3'b010, 32'h8000_0020, 32'h0, 8'h33, 32'hDEAD_BEEF,
           1'b1, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b0, 5, 3, w, r0);
    chk("bp_out_latency", 32'(w), 32'd2);

    // reset while waiting for the response, then a stray response
    resp_en       = 1'b0;
    mem_req_ready = 1'b1;
    exp_req.push_back('{32'h8000_0040, 1'b0, 32'h0, 4'b0000});
    n_exp_req++;
    in_valid = 1'b1;
    in_wen   = 1'b0;
    in_width = 3'b010;
    in_addr  = 32'h8000_0040;
    in_tag   = 8'h44;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk1("resp_state_req_valid", mem_req_valid, 1'b0);
    chk1("resp_state_in_ready", in_ready, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    resp_en = 1'b1;
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_in_ready", in_ready, 1'b1);
    chk1("midrst_req_valid", mem_req_valid, 1'b0);
    resp_data  = 32'hDEAD_DEAD;
    force_resp = 1'b1;
    @(posedge clk);
    #1;
    force_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk1("stray_out_valid", out_valid, 1'b0);
      chk1("stray_in_ready", in_ready, 1'b1);
    end
    chk("stray_req_count", 32'(req_cnt), 32'(n_exp_req));

    run_op(1'b0, 3'b101, 32'h8000_0000, 32'h0, 8'h55, 32'h1234_ABCD,
           1'b1, 32'h0, 4'b0000, 32'h0000_ABCD, 1'b0, 0, 0, w, r0);

`ifdef LSU_MISALIGN_CHECK_EN
    run_op(1'b0, 3'b010, 32'h8000_0002, 32'h0, 8'h5A, 32'h1122_3344,
           1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 0, 0, w, r0);
    chk1("mis_lw_no_req", r0, 1'b0);
    chk("mis_lw_latency", 32'(w), 32'd0);
    run_op(1'b0, 3'b001, 32'h8000_0001, 32'h0, 8'h5B, 32'h0000_F00F,
           1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 0, 0, w, r0);
    chk1("mis_lh_no_req", r0, 1'b0);
    run_op(1'b1, 3'b001, 32'h8000_0003, 32'h0000_1234, 8'h5C, 32'h0,
           1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 0, 0, w, r0);
    run_op(1'b0, 3'b000, 32'h8000_0003, 32'h0, 8'h5D, 32'h8000_0000,
           1'b1, 32'h0, 4'b0000, 32'hFFFF_FF80, 1'b0, 0, 0, w, r0);
`else
    run_op(1'b0, 3'b010, 32'h8000_0002, 32'h0, 8'h5A, 32'h1122_3344,
           1'b1, 32'h0, 4'b0000, 32'h1122_3344, 1'b0, 0, 0, w, r0);
    chk1("mis_lw_req_issued", r0, 1'b1);
    run_op(1'b0, 3'b001, 32'h8000_0001, 32'h0, 8'h5B, 32'h0000_F00F,
           1'b1, 32'h0, 4'b0000, 32'hFFFF_F00F, 1'b0, 0, 0, w, r0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("req_queue_empty", 32'(exp_req.size()), 32'd0);
    chk("out_queue_empty", 32'(exp_out.size()), 32'd0);
    chk("final_req_count", 32'(req_cnt), 32'(n_exp_req));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
